instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter DATA_W, default 16, instruction word width.
REQ-002 Parameter DEPTH, default 4, prefetch buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 label  input  8  branch target address.
REQ-006 branch  input  1  one-cycle redirect strobe; fetch restarts at label.
REQ-007 mem_addr  output  8  instruction memory read address.
REQ-008 mem_req  output  1  read request.
REQ-009 mem_ack  input  1  read completion; mem_data valid in the same cycle.
REQ-010 mem_data  input  DATA_W  read data.
REQ-011 instr  output  DATA_W  head-of-buffer instruction.
REQ-012 instr_pc  output  8  address of instr.
REQ-013 instr_valid  output  1  instr/instr_pc valid.
REQ-014 instr_ready  input  1  decoder accepts head entry.

Function
REQ-015 FSM states SHALL be IDLE, REQ, DISCARD; at most one memory request outstanding.
REQ-016 Internal fetch_addr (8 bit) SHALL drive mem_addr; increments by 1 per accepted fetch, 255 wraps to 0.
REQ-017 Handshake: once mem_req is high, mem_req and mem_addr SHALL stay stable until a cycle with mem_ack high.
REQ-018 IDLE -> REQ when count < DEPTH and branch low; mem_req high in REQ and DISCARD only.
REQ-019 REQ with mem_ack: push {mem_data, mem_addr}, fetch_addr+1; stay REQ if next-cycle count < DEPTH, else IDLE (back-to-back fetch, no idle bubble).
REQ-020 mem_ack while mem_req low SHALL be ignored.
REQ-021 instr_valid = (count != 0); instr/instr_pc = head entry; pop when instr_valid and instr_ready.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; push when full never occurs (no request issued at count == DEPTH).
REQ-023 branch high: buffer cleared (count 0, pop ignored), fetch_addr <= label; next cycle instr_valid low.
REQ-024 branch in IDLE or in REQ with mem_ack same cycle -> state REQ next cycle with mem_addr = label (acked data discarded).
REQ-025 branch in REQ without mem_ack -> DISCARD; mem_addr held; on mem_ack data dropped, then REQ at label.
REQ-026 branch during DISCARD SHALL update fetch_addr to newest label; state stays DISCARD until mem_ack.
REQ-027 Fetch latency: first instr_valid SHALL rise the cycle after the mem_ack that carries it.

Reset
REQ-028 reset low SHALL immediately force: state IDLE, mem_req 0, mem_addr 0, count 0, instr_valid 0, instr 0, instr_pc 0.
REQ-029 reset asserted mid-request SHALL drop mem_req asynchronously; no partial entry is written; first request after release is to address 0.

Verification
REQ-030 Release reset, memory acks every cycle returning data=addr+0x100, instr_ready=1 -> instr_pc 0,1,2,... each cycle, instr = 0x100,0x101,...
REQ-031 instr_ready=0, acks immediate -> exactly 4 entries (pc 0..3) buffered, mem_req low with mem_addr 4; raise ready -> fetch resumes at 4.
REQ-032 Start at fetch_addr 254 (via branch label=254) -> instr_pc sequence 254,255,0,1.
REQ-033 branch label=0x40 while request to 0x05 waits 3 cycles for ack -> mem_addr holds 0x05 until ack, data dropped, next request 0x40, first instr_pc 0x40.
REQ-034 reset pulsed low with mem_req high and 2 entries buffered -> mem_req and instr_valid low immediately; after release first mem_addr 0.
REQ-035 Ack delay randomised 0-5 cycles, random instr_ready, random branches -> instr_pc always sequential except at redirect, where it equals last label; no entry lost or duplicated.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Instruction prefetch unit. Fetches sequential instruction
//               words from memory into a small FIFO with at most one read
//               outstanding, and redirects the fetch stream on a branch.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1       clock, rising edge
//   reset        in   1       asynchronous reset, active low
//   label        in   8       branch target address
//   branch       in   1       one-cycle redirect strobe
//   mem_addr     out  8       instruction memory read address
//   mem_req      out  1       read request (held until mem_ack)
//   mem_ack      in   1       read completion, mem_data valid same cycle
//   mem_data     in   DATA_W  read data
//   instr        out  DATA_W  head-of-buffer instruction
//   instr_pc     out  8       address of instr
//   instr_valid  out  1       instr/instr_pc valid
//   instr_ready  in   1       decoder accepts head entry
// ============================================================================
module instruction_fetch #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        label,
  input  logic              branch,
  output logic [7:0]        mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic [7:0]        instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t             state_q,      state_d;
  logic [7:0]         fetch_addr_q, fetch_addr_d;
  logic [7:0]         mem_addr_q,   mem_addr_d;
  logic               mem_req_q,    mem_req_d;
  logic [CNT_W-1:0]   count_q,      count_d;
  logic [PTR_W-1:0]   rd_ptr_q,     rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q,     wr_ptr_d;
  logic [DATA_W-1:0]  buf_data_q [DEPTH];
  logic [DATA_W-1:0]  buf_data_d [DEPTH];
  logic [7:0]         buf_pc_q   [DEPTH];
  logic [7:0]         buf_pc_d   [DEPTH];

  logic push;
  logic pop;

  always_comb begin
    // A branch kills both the returning data and any consumption this cycle.
    push = (state_q == REQ) && mem_ack && !branch;
    pop  = (count_q != '0) && instr_ready && !branch;

    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    if (push) begin
      buf_data_d[wr_ptr_q] = mem_data;
      buf_pc_d[wr_ptr_q]   = mem_addr_q;
    end

    if (branch) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    if (branch) begin
      fetch_addr_d = label;
    end else if (push) begin
      fetch_addr_d = fetch_addr_q + 8'd1;
    end else begin
      fetch_addr_d = fetch_addr_q;
    end

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (branch || (count_q < DEPTH_C)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          // Keep requesting back-to-back while the buffer has room.
          if (branch || (count_d < DEPTH_C)) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (branch) begin
          // The in-flight read must still complete; its data is dropped.
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_req_d  = (state_d != IDLE);
    // While draining a stale read the bus address stays on the old request;
    // the new target is parked in fetch_addr until the ack arrives.
    mem_addr_d = (state_d == DISCARD) ? mem_addr_q : fetch_addr_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= 8'd0;
      mem_addr_q   <= 8'd0;
      mem_req_q    <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= 8'd0;
      end
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      buf_data_q   <= buf_data_d;
      buf_pc_q     <= buf_pc_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_req     = mem_req_q;
  assign instr       = buf_data_q[rd_ptr_q];
  assign instr_pc    = buf_pc_q[rd_ptr_q];
  assign instr_valid = (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch. A memory model
//               answers requests with programmable latency; accepted fetches
//               are queued as expected entries and compared on every pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  label;
  logic        branch;
  logic [7:0]  mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  instruction_fetch #(.DATA_W(16), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .label       (label),
    .branch      (branch),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] data;
  } ent_t;

  ent_t sb[$];

  int checks = 0;
  int errors = 0;

  // memory model / stimulus knobs
  int         kmin = 0, kmax = 0, ready_pct = 100, branch_pct = 0;
  bit         force_br = 0;
  logic [7:0] force_lbl = 8'd0;
  bit         out_active = 0, out_stale = 0;
  logic [7:0] out_addr = 8'd0;
  int         out_wait = 0, out_delay = 0;
  logic [7:0] exp_fetch = 8'd0;
  int         pops = 0;
  // one-shot trap: stall a given request 3 cycles and branch as it starts
  bit         trap_en = 0, trap_hit = 0, trap_wait_ack = 0, expect_redirect = 0;
  bit         redirect_seen = 0;
  logic [7:0] trap_addr = 8'd0, trap_lbl = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return 16'h0100 + {8'h00, a};
  endfunction

  // One clock cycle: sample outputs at the falling edge, choose and drive
  // inputs, then advance the model by what the next rising edge commits.
  task automatic step();
    logic       req, iv, br, rdy, ack;
    logic [7:0] addr, ipc, lbl;
    logic [15:0] idat;
    ent_t       e;
    @(negedge clk);
    req  = mem_req;
    addr = mem_addr;
    iv   = instr_valid;
    ipc  = instr_pc;
    idat = instr;
    check("valid", 32'(iv), 32'(sb.size() != 0));

    br  = ($urandom_range(99) < branch_pct);
    lbl = 8'($urandom);
    if (force_br) begin
      br = 1'b1;
      lbl = force_lbl;
      force_br = 0;
    end

    ack = 1'b0;
    if (req) begin
      if (!out_active) begin
        out_active = 1;
        out_addr   = addr;
        out_stale  = 0;
        out_wait   = 0;
        out_delay  = int'($urandom_range(kmax, kmin));
        if (expect_redirect) begin
          check("redirect_addr", 32'(addr), 32'(trap_lbl));
          expect_redirect = 0;
          redirect_seen = 1;
        end
        if (trap_en && addr == trap_addr) begin
          out_delay = 3;
          br = 1'b1;
          lbl = trap_lbl;
          trap_en = 0;
          trap_hit = 1;
          trap_wait_ack = 1;
        end
      end else begin
        check("addr_hold", 32'(addr), 32'(out_addr));
      end
      if (out_wait >= out_delay) ack = 1'b1;
      else out_wait++;
    end else begin
      if (out_active) begin
        check("req_held", 32'(req), 32'd1);
        out_active = 0;
      end
      // stray acks with no request pending must be ignored
      ack = ($urandom_range(3) == 0);
    end
    rdy = ($urandom_range(99) < ready_pct);

    branch      = br;
    label       = lbl;
    instr_ready = rdy;
    mem_ack     = ack;
    mem_data    = (req && ack) ? mem_word(addr) : 16'($urandom);

    if (iv && rdy && !br) begin
      pops++;
      if (sb.size() == 0) begin
        check("pop_empty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("instr_pc", 32'(ipc), 32'(e.pc));
        check("instr", 32'(idat), 32'(e.data));
      end
    end
    if (req && br) out_stale = 1;
    if (req && ack) begin
      if (!out_stale) begin
        check("fetch_addr", 32'(addr), 32'(exp_fetch));
        sb.push_back('{pc: addr, data: mem_word(addr)});
        exp_fetch = exp_fetch + 8'd1;
      end
      if (trap_wait_ack) begin
        trap_wait_ack = 0;
        expect_redirect = 1;
      end
      out_active = 0;
    end
    if (br) begin
      sb.delete();
      exp_fetch = lbl;
    end
    if (sb.size() > 4) check("overfill", 32'(sb.size()), 32'd4);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_clear();
    sb.delete();
    out_active = 0;
    out_stale = 0;
    exp_fetch = 8'd0;
    trap_wait_ack = 0;
    expect_redirect = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    branch = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    model_clear();
    reset = 1'b1;
  endtask

  initial begin
    int p0;
    int guard;
    reset = 1'b0;
    label = 8'd0;
    branch = 1'b0;
    mem_ack = 1'b0;
    mem_data = 16'd0;
    instr_ready = 1'b0;
    #3;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    model_clear();
    reset = 1'b1;

    // streaming: immediate acks, always ready
    kmin = 0; kmax = 0; ready_pct = 100; branch_pct = 0;
    pops = 0;
    run(20);
    check("stream_pops", 32'(pops >= 18), 32'd1);

    // buffer fills to DEPTH with the decoder stalled
    apply_reset();
    ready_pct = 0;
    run(12);
    check("full_mem_req", 32'(mem_req), 32'd0);
    check("full_mem_addr", 32'(mem_addr), 32'd4);
    check("full_valid", 32'(instr_valid), 32'd1);
    check("full_pc", 32'(instr_pc), 32'd0);
    ready_pct = 100;
    run(12);

    // address wrap 254 -> 255 -> 0 -> 1
    force_br = 1; force_lbl = 8'd254;
    p0 = pops;
    run(10);
    check("wrap_pops", 32'(pops - p0 >= 4), 32'd1);

    // branch while a slow request to 0x05 is outstanding
    apply_reset();
    trap_en = 1; trap_addr = 8'h05; trap_lbl = 8'h40; trap_hit = 0; redirect_seen = 0;
    run(25);
    check("trap_hit", 32'(trap_hit), 32'd1);
    check("redirect_seen", 32'(redirect_seen), 32'd1);

    // asynchronous reset with a request pending and two entries buffered
    apply_reset();
    ready_pct = 0;
    guard = 0;
    while (!(sb.size() == 2 && mem_req) && guard < 20) begin
      step();
      guard++;
    end
    check("two_buffered", 32'(sb.size() == 2 && mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_mem_req", 32'(mem_req), 32'd0);
    check("async_valid", 32'(instr_valid), 32'd0);
    check("async_mem_addr", 32'(mem_addr), 32'd0);
    check("async_instr", 32'(instr), 32'd0);
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_clear();
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_req", 32'(mem_req), 32'd1);
    check("post_rst_addr", 32'(mem_addr), 32'd0);
    ready_pct = 100;
    run(10);

    // random latency, ready and branches
    kmin = 0; kmax = 5; ready_pct = 60; branch_pct = 4;
    p0 = pops;
    run(3000);
    check("random_progress", 32'(pops - p0 > 300), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
